// File: rtl/ofm_wb_pkg.sv
// Shared types and constants for the OFM write-back address generator.
package ofm_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_STRIDE = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/pe_vector_serializer.sv
// Holds one PE result vector and emits it one lane per accepted write.
module pe_vector_serializer #(
    parameter int TOTAL_PE   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_accept_en,
    input  logic                           i_in_valid,
    input  logic [TOTAL_PE*DATA_WIDTH-1:0] i_in_data,
    output logic                           o_in_ready,
    output logic                           o_out_valid,
    output logic [DATA_WIDTH-1:0]          o_out_data,
    input  logic                           i_out_ready,
    output logic                           o_out_last
);

    logic [TOTAL_PE-1:0][DATA_WIDTH-1:0] r_cur_vec;
    logic                                r_cur_valid;
    logic [LANE_W-1:0]                   r_lane;
    logic                                w_out_hs;
    logic                                w_in_hs;

    assign o_out_last  = (r_lane == LANE_W'(TOTAL_PE - 1));
    assign w_out_hs    = r_cur_valid && i_out_ready;
    // A new vector may land in the same cycle the last lane of the old one drains.
    assign o_in_ready  = i_accept_en && (!r_cur_valid || (w_out_hs && o_out_last));
    assign w_in_hs     = i_in_valid && o_in_ready;
    assign o_out_valid = r_cur_valid;
    assign o_out_data  = r_cur_vec[r_lane];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_vec   <= '0;
            r_cur_valid <= 1'b0;
            r_lane      <= '0;
        end else begin
            if (w_in_hs) begin
                r_cur_vec   <= i_in_data;
                r_cur_valid <= 1'b1;
            end else if (w_out_hs && o_out_last) begin
                r_cur_valid <= 1'b0;
            end
            if (w_out_hs) r_lane <= o_out_last ? '0 : r_lane + 1'b1;
        end
    end

endmodule

// File: rtl/ofm_writeback_addr_gen.sv
// Serializes PE result vectors into a contiguous HWC word-write stream to the OFM buffer.
module ofm_writeback_addr_gen
    import ofm_wb_pkg::*;
#(
    parameter int TOTAL_PE   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_start,
    input  logic [ADDR_WIDTH-1:0]          i_base_addr,
    input  logic [7:0]                     i_ofm_w,
    input  logic [7:0]                     i_ofm_c,
    input  logic                           i_in_valid,
    input  logic [TOTAL_PE*DATA_WIDTH-1:0] i_in_data,
    output logic                           o_in_ready,
    output logic                           o_wr_en,
    output logic [ADDR_WIDTH-1:0]          o_wr_addr,
    output logic [DATA_WIDTH-1:0]          o_wr_data,
    input  logic                           i_wr_ready,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_cfg_err
);

    localparam int LOG2_PE = clog2(TOTAL_PE);

    state_t                r_state, w_state_nxt;
    logic [23:0]           r_total_vec;
    logic [23:0]           r_vec_cnt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_cfg_err;

    logic        w_cfg_bad;
    logic        w_start_ok;
    logic [23:0] w_num_tiles;
    logic [23:0] w_total_vec;
    logic        w_accept_en;
    logic        w_in_hs;
    logic        w_wr_hs;
    logic        w_last_lane;
    logic        w_final_wr;

    assign w_cfg_bad   = (i_ofm_w == 8'd0) || (i_ofm_c == 8'd0) ||
                         (i_ofm_c[LOG2_PE-1:0] != '0);
    assign w_start_ok  = (r_state == IDLE) && i_start && !w_cfg_bad;
    assign w_num_tiles = 24'(i_ofm_c >> LOG2_PE);
    assign w_total_vec = 24'(i_ofm_w) * 24'(i_ofm_w) * w_num_tiles;

    assign w_accept_en = (r_state == RUN) && (r_vec_cnt < r_total_vec);
    assign w_in_hs     = i_in_valid && o_in_ready;
    assign w_wr_hs     = o_wr_en && i_wr_ready;
    // No vector can be accepted once the count is reached, so this is the stream's last word.
    assign w_final_wr  = w_wr_hs && w_last_lane && (r_vec_cnt == r_total_vec);

    pe_vector_serializer #(
        .TOTAL_PE   (TOTAL_PE),
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_W     (LOG2_PE)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_accept_en (w_accept_en),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_wr_en),
        .o_out_data  (o_wr_data),
        .i_out_ready (i_wr_ready),
        .o_out_last  (w_last_lane)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = RUN;
            RUN:     if (w_final_wr) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_total_vec <= '0;
            r_vec_cnt   <= '0;
            r_ptr       <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= (r_state == IDLE) && i_start && w_cfg_bad;
            if (w_start_ok) begin
                r_total_vec <= w_total_vec;
                r_vec_cnt   <= '0;
                r_ptr       <= i_base_addr;
            end else begin
                if (w_in_hs) r_vec_cnt <= r_vec_cnt + 24'd1;
                if (w_wr_hs) r_ptr     <= r_ptr + ADDR_WIDTH'(WORD_STRIDE);
            end
        end
    end

    assign o_wr_addr = r_ptr;
    assign o_busy    = (r_state == RUN);
    assign o_done    = (r_state == DONE);
    assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_ofm_writeback_addr_gen.sv
// Directed table-driven bench for ofm_writeback_addr_gen with TOTAL_PE=4.
module tb_ofm_writeback_addr_gen;

    localparam int PE = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [AW-1:0]     i_base_addr;
    logic [7:0]        i_ofm_w;
    logic [7:0]        i_ofm_c;
    logic              i_in_valid;
    logic [PE*DW-1:0]  i_in_data;
    logic              o_in_ready;
    logic              o_wr_en;
    logic [AW-1:0]     o_wr_addr;
    logic [DW-1:0]     o_wr_data;
    logic              i_wr_ready;
    logic              o_busy;
    logic              o_done;
    logic              o_cfg_err;

    ofm_writeback_addr_gen #(.TOTAL_PE(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_ofm_w     (i_ofm_w),
        .i_ofm_c     (i_ofm_c),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .i_wr_ready  (i_wr_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_cfg_err   (o_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [7:0]  w;
        logic [7:0]  c;
        int          gap;       // idle in_valid cycles after each accepted vector
        bit          stall;     // wr_ready pattern 1,0,0,1
        int          abort_at;  // reset after this many writes (0 = run to done)
        bit          exp_err;
        int          nvec;      // vectors to offer
        int          exp_n;     // writes expected
    } case_t;

    case_t tbl[9];
    int    n_checks;
    int    n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " wr_en"},    32'(o_wr_en),    32'd0);
        chk({tag, " wr_addr"},  o_wr_addr,       32'd0);
        chk({tag, " wr_data"},  o_wr_data,       32'd0);
        chk({tag, " in_ready"}, 32'(o_in_ready), 32'd0);
        chk({tag, " busy"},     32'(o_busy),     32'd0);
        chk({tag, " done"},     32'(o_done),     32'd0);
        chk({tag, " cfg_err"},  32'(o_cfg_err),  32'd0);
    endtask

    function automatic logic [31:0] word_of(input int seed, input int j);
        return {8'(seed), 24'(j)};
    endfunction

    task automatic drive_vec(input int seed, input int v);
        for (int k = 0; k < PE; k++) i_in_data[k*DW +: DW] = word_of(seed, v*PE + k);
    endtask

    task automatic run_case(input case_t tc, input int seed);
        int           n_wr, next_vec, gap_cnt, cyc, acc_cyc, last_wr_cyc, first_wr_cyc;
        bit           prev_stall, done_seen;
        logic [31:0]  prev_addr, prev_data;
        n_wr = 0; next_vec = 0; gap_cnt = 0; cyc = 0;
        acc_cyc = -10; last_wr_cyc = -10; first_wr_cyc = -1;
        prev_stall = 0; done_seen = 0; prev_addr = '0; prev_data = '0;

        @(negedge clk);
        i_base_addr = tc.base; i_ofm_w = tc.w; i_ofm_c = tc.c;
        i_in_valid = 1'b0; i_wr_ready = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        if (tc.exp_err) begin
            chk("cfg_err pulse", 32'(o_cfg_err), 32'd1);
            chk("busy after bad start", 32'(o_busy), 32'd0);
            i_in_valid = 1'b1;
            drive_vec(seed, 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); #1;
                chk("cfg_err drops", 32'(o_cfg_err), 32'd0);
                chk("no write after bad start", 32'(o_wr_en), 32'd0);
                chk("in_ready idle", 32'(o_in_ready), 32'd0);
                chk("busy idle", 32'(o_busy), 32'd0);
            end
            i_in_valid = 1'b0;
            return;
        end
        chk("busy after start", 32'(o_busy), 32'd1);
        chk("no cfg_err on good start", 32'(o_cfg_err), 32'd0);

        while (cyc < 2000) begin
            i_wr_ready = tc.stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            i_in_valid = (next_vec < tc.nvec) && (gap_cnt == 0);
            drive_vec(seed, next_vec);
            #1;
            if (acc_cyc == cyc - 1) chk("wr_en one cycle after accept", 32'(o_wr_en), 32'd1);
            if (prev_stall) begin
                chk("stall wr_en held", 32'(o_wr_en), 32'd1);
                chk("stall addr held", o_wr_addr, prev_addr);
                chk("stall data held", o_wr_data, prev_data);
            end
            if (o_wr_en && !i_wr_ready) chk("in_ready low while stalled", 32'(o_in_ready), 32'd0);
            if (o_done) begin
                chk("done after final write", 32'(last_wr_cyc), 32'(cyc - 1));
                chk("write count at done", 32'(n_wr), 32'(tc.exp_n));
                chk("busy low at done", 32'(o_busy), 32'd0);
                done_seen = 1;
                break;
            end
            if (i_in_valid && o_in_ready) begin
                next_vec++;
                gap_cnt = tc.gap;
                acc_cyc = cyc;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            if (o_wr_en && i_wr_ready) begin
                chk("wr_addr", o_wr_addr, tc.base + 32'(4 * n_wr));
                chk("wr_data", o_wr_data, word_of(seed, n_wr));
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                n_wr++;
                last_wr_cyc = cyc;
            end
            prev_stall = o_wr_en && !i_wr_ready;
            prev_addr  = o_wr_addr;
            prev_data  = o_wr_data;
            if (tc.abort_at != 0 && n_wr == tc.abort_at) break;
            @(negedge clk);
            cyc++;
        end

        if (tc.abort_at != 0) begin
            chk("writes before abort", 32'(n_wr), 32'(tc.abort_at));
            @(negedge clk);
            i_in_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk_reset_outputs("mid-run reset");
            @(negedge clk); #1;
            chk_reset_outputs("held reset");
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end

        if (!done_seen) begin
            n_checks++; n_fail++;
            $display("FAIL done timeout: got %0d writes expected %0d", n_wr, tc.exp_n);
        end
        if (tc.gap == 0 && !tc.stall)
            chk("no bubbles", 32'(last_wr_cyc - first_wr_cyc), 32'(tc.exp_n - 1));
        i_in_valid = 1'b0;
        @(negedge clk); #1;
        chk("done is one pulse", 32'(o_done), 32'd0);
        chk("busy stays low", 32'(o_busy), 32'd0);
        chk("no stray write", 32'(o_wr_en), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        //          base           w     c     gap stall abort err nvec exp_n
        tbl[0] = '{32'h0000_1000, 8'd2, 8'd8, 0, 1'b0, 0, 1'b0, 8,  32};
        tbl[1] = '{32'h0000_1000, 8'd2, 8'd8, 0, 1'b1, 0, 1'b0, 8,  32};
        tbl[2] = '{32'h0000_2000, 8'd2, 8'd8, 3, 1'b0, 0, 1'b0, 8,  32};
        tbl[3] = '{32'h0000_1000, 8'd2, 8'd6, 0, 1'b0, 0, 1'b1, 0,  0};
        tbl[4] = '{32'h0000_1000, 8'd0, 8'd4, 0, 1'b0, 0, 1'b1, 0,  0};
        tbl[5] = '{32'hFFFF_FFF8, 8'd1, 8'd4, 0, 1'b0, 0, 1'b0, 1,  4};
        tbl[6] = '{32'h0000_3000, 8'd2, 8'd8, 0, 1'b0, 5, 1'b0, 8,  5};
        tbl[7] = '{32'h0000_4000, 8'd1, 8'd4, 0, 1'b0, 0, 1'b0, 1,  4};
        tbl[8] = '{32'h0000_0500, 8'd3, 8'd4, 1, 1'b1, 0, 1'b0, 9,  36};

        rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_ofm_w = '0; i_ofm_c = '0;
        i_in_valid = 1'b0; i_in_data = '0; i_wr_ready = 1'b0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Vectors offered in IDLE must not be taken.
        i_in_valid = 1'b1;
        @(negedge clk); #1;
        chk("in_ready in IDLE", 32'(o_in_ready), 32'd0);
        i_in_valid = 1'b0;

        for (int t = 0; t < 9; t++) run_case(tbl[t], t + 1);

        // start while busy is ignored and raises no error.
        @(negedge clk);
        i_base_addr = 32'h0000_6000; i_ofm_w = 8'd1; i_ofm_c = 8'd4; i_start = 1'b1;
        @(negedge clk);
        i_base_addr = 32'h0000_7000; i_ofm_c = 8'd6;
        #1;
        chk("busy for second start test", 32'(o_busy), 32'd1);
        @(negedge clk);
        i_start = 1'b0;
        #1;
        chk("no cfg_err for start in RUN", 32'(o_cfg_err), 32'd0);
        chk("base kept on start in RUN", o_wr_addr, 32'h0000_6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
